vslc_eeprom_arbiter: RTL and testbench

//  Owns the external SPI serial EEPROM (25xx family, 16-bit address) and shares it between two

---
 rtl/vslc_pkg.sv | 19 +
 rtl/vslc_spi_shifter.sv | 71 +++++++
 rtl/vslc_eeprom_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_vslc_eeprom_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared constants for the VSLC serial-EEPROM read arbiter: READ opcode,
// arbiter state encoding and requester port indices.
package vslc_pkg;

    localparam logic [7:0] EEPROM_READ_CMD = 8'h03;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t StIdle  = 3'd0;
    localparam arb_state_t StSetup = 3'd1;
    localparam arb_state_t StCmd   = 3'd2;
    localparam arb_state_t StAddr  = 3'd3;
    localparam arb_state_t StData  = 3'd4;
    localparam arb_state_t StGap   = 3'd5;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_CFG    = 1'b1;

endpackage

// File: rtl/vslc_spi_shifter.sv
// SPI mode-0 bit engine at clk/2: sck phase toggle, bit counter, MSB-first byte
// shift-out on copi and shift-in from cipo, with a strobe on each completed byte.
module vslc_spi_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       en_i,
    input  logic [7:0] next_byte_i,
    input  logic       cipo_i,
    output logic       sck_o,
    output logic       copi_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    logic       phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] rx_q, rx_d;
    logic       byte_done;

    always_comb begin
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        byte_done = 1'b0;
        if (start_i) begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            tx_d      = next_byte_i;
        end else if (!en_i) begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (!phase_q) begin
            phase_d = 1'b1;
        end else begin
            // Edge that drops sck samples cipo and moves copi to the next bit.
            phase_d = 1'b0;
            rx_d    = {rx_q[5:0], cipo_i};
            if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
                bit_cnt_d = 3'd0;
                tx_d      = next_byte_i;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                tx_d      = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'h00;
            rx_q      <= 7'h00;
        end else begin
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    assign sck_o       = phase_q;
    assign copi_o      = tx_q[7];
    assign byte_done_o = byte_done;
    assign rx_byte_o   = {rx_q, cipo_i};

endmodule

// File: rtl/vslc_eeprom_arbiter.sv
// Two-port round-robin arbiter owning a 25xx SPI EEPROM; each grant runs one
// READ (0x03 + address) and streams a burst of bytes back to the winner.
module vslc_eeprom_arbiter
    import vslc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CS_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_copi,
    input  logic              spi_cipo
);

    // Address goes out a byte at a time, so ADDR_W is expected to be a multiple of 8.
    localparam int unsigned ADDR_BYTES = ADDR_W / 8;
    localparam int unsigned ABYTE_W    = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int unsigned GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    arb_state_t         state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_port_q, last_port_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic [ABYTE_W-1:0] abyte_cnt_q, abyte_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               abort_q, abort_d;
    logic               cs_n_q, cs_n_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic       sh_start;
    logic       sh_en;
    logic [7:0] sh_next_byte;
    logic       sh_byte_done;
    logic [7:0] sh_rx_byte;
    logic       win;
    logic       cur_port;
    logic       req_lost;
    logic       addr_last;

    assign cur_port  = gnt_q[PORT_CFG] ? PORT_CFG : PORT_IFETCH;
    assign addr_last = (abyte_cnt_q == ABYTE_W'(ADDR_BYTES - 1));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_port_d  = last_port_q;
        addr_d       = addr_q;
        len_cnt_d    = len_cnt_q;
        abyte_cnt_d  = abyte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        abort_d      = abort_q;
        cs_n_d       = cs_n_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        rd_data_d    = rd_data_q;
        sh_start     = 1'b0;
        sh_en        = 1'b0;
        sh_next_byte = 8'h00;
        win          = 1'b0;
        req_lost     = 1'b0;

        case (state_q)
            StIdle: begin
                sh_next_byte = EEPROM_READ_CMD;
                if (req != 2'b00) begin
                    // Contention goes to whichever port was not served last.
                    win         = (req == 2'b11) ? ~last_port_q : req[PORT_CFG];
                    gnt_d       = 2'b00;
                    gnt_d[win]  = 1'b1;
                    last_port_d = win;
                    addr_d      = win ? addr1 : addr0;
                    len_cnt_d   = win ? len1 : len0;
                    abort_d     = 1'b0;
                    cs_n_d      = 1'b0;
                    sh_start    = 1'b1;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                state_d = StCmd;
            end
            StCmd: begin
                sh_en        = 1'b1;
                sh_next_byte = addr_q[ADDR_W-1 -: 8];
                if (sh_byte_done) begin
                    addr_d      = addr_q << 8;
                    abyte_cnt_d = '0;
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                sh_en        = 1'b1;
                sh_next_byte = addr_last ? 8'h00 : addr_q[ADDR_W-1 -: 8];
                if (sh_byte_done) begin
                    if (addr_last) begin
                        state_d = StData;
                    end else begin
                        addr_d      = addr_q << 8;
                        abyte_cnt_d = abyte_cnt_q + ABYTE_W'(1);
                    end
                end
            end
            StData: begin
                sh_en    = 1'b1;
                req_lost = abort_q | ~req[cur_port];
                abort_d  = req_lost;
                if (sh_byte_done) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = sh_rx_byte;
                    if ((len_cnt_q == '0) || req_lost) begin
                        rd_last_d = 1'b1;
                        cs_n_d    = 1'b1;
                        gap_cnt_d = GAP_W'(CS_GAP - 1);
                        state_d   = StGap;
                    end else begin
                        len_cnt_d = len_cnt_q - LEN_W'(1);
                    end
                end
            end
            StGap: begin
                // gnt drops one edge after the final rd_valid so they never disagree.
                gnt_d = 2'b00;
                if (gap_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= 2'b00;
            last_port_q <= PORT_CFG;
            addr_q      <= '0;
            len_cnt_q   <= '0;
            abyte_cnt_q <= '0;
            gap_cnt_q   <= '0;
            abort_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_port_q <= last_port_d;
            addr_q      <= addr_d;
            len_cnt_q   <= len_cnt_d;
            abyte_cnt_q <= abyte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            abort_q     <= abort_d;
            cs_n_q      <= cs_n_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    vslc_spi_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (sh_start),
        .en_i        (sh_en),
        .next_byte_i (sh_next_byte),
        .cipo_i      (spi_cipo),
        .sck_o       (spi_sck),
        .copi_o      (spi_copi),
        .byte_done_o (sh_byte_done),
        .rx_byte_o   (sh_rx_byte)
    );

    assign gnt      = gnt_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state_q != StIdle);
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_vslc_eeprom_arbiter.sv
// Bench for vslc_eeprom_arbiter: a behavioural 25xx EEPROM on the SPI pins plus
// directed and randomized read transactions checked against an arbitration model.
module tb_vslc_eeprom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic [1:0]  gnt;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_last, busy;
    logic        spi_cs_n, spi_sck, spi_copi;
    logic        spi_cipo = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [0:65535];

    // EEPROM model state
    int          m_bits = 0;
    logic        m_sck_prev = 1'b0;
    logic        m_cs_prev = 1'b1;
    logic [23:0] m_shift = '0;
    logic [7:0]  seen_cmd;
    logic [15:0] seen_addr;
    logic [7:0]  m_byte;
    int          m_idx;
    int          high_run = 0;
    int          last_high_run = 0;

    logic        last_win;
    logic [1:0]  r;
    logic        w;

    vslc_eeprom_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr0    (addr0),
        .len0     (len0),
        .addr1    (addr1),
        .len1     (len1),
        .gnt      (gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_copi (spi_copi),
        .spi_cipo (spi_cipo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Device: samples copi on sck rise, shifts data out on sck fall after 24 bits.
    always @(negedge clk) begin
        if (spi_cs_n) begin
            m_bits     = 0;
            m_sck_prev = 1'b0;
            m_cs_prev  = 1'b1;
            spi_cipo   = 1'b0;
            high_run++;
        end else begin
            if (m_cs_prev) begin
                seen_cmd      = 'x;
                seen_addr     = 'x;
                last_high_run = high_run;
                high_run      = 0;
            end
            m_cs_prev = 1'b0;
            if (spi_sck && !m_sck_prev) begin
                if (m_bits < 24) m_shift = {m_shift[22:0], spi_copi};
                m_bits++;
                if (m_bits == 24) begin
                    seen_cmd  = m_shift[23:16];
                    seen_addr = m_shift[15:0];
                end
            end else if (!spi_sck && m_sck_prev && m_bits >= 24) begin
                m_idx    = m_bits - 24;
                m_byte   = mem[16'(seen_addr + 16'(m_idx / 8))];
                spi_cipo = m_byte[7 - (m_idx % 8)];
            end
            m_sck_prev = spi_sck;
        end
    end

    always @(negedge clk) begin
        if (rd_valid) check("valid_without_gnt", 32'(gnt != 2'b00), 32'd1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // One granted READ: checks grant, latency, data, last flag, SPI header and gap.
    task automatic txn(input logic [1:0] exp_g, input int n_exp, input int drop_at,
                       input bit keep);
        int t;
        int n;
        int g_cyc;
        int prev_cyc;
        bit done;
        logic [15:0] a;
        a = exp_g[1] ? addr1 : addr0;
        t = 0;
        while (gnt === 2'b00 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("grant_seen", 32'(gnt !== 2'b00), 32'd1);
        if (gnt === 2'b00) return;
        g_cyc = cyc;
        prev_cyc = cyc;
        check("gnt", 32'(gnt), 32'(exp_g));
        check("busy_in_txn", 32'(busy), 32'd1);
        last_win = exp_g[1];
        n = 0;
        done = 1'b0;
        t = 0;
        while (!done && t < 16 * n_exp + 200) begin
            if (drop_at >= 0 && cyc - g_cyc == drop_at) req = req & ~exp_g;
            if (rd_valid) begin
                if (n == 0) check("first_latency", 32'(cyc - g_cyc), 32'd65);
                else check("byte_spacing", 32'(cyc - prev_cyc), 32'd16);
                prev_cyc = cyc;
                check("rd_data", 32'(rd_data), 32'(mem[16'(a + 16'(n))]));
                check("rd_last", 32'(rd_last), 32'(n == n_exp - 1));
                n++;
                if (rd_last) begin
                    done = 1'b1;
                    check("cs_high_at_last", 32'(spi_cs_n), 32'd1);
                    if (!keep) req = 2'b00;
                end
            end
            if (!done) begin
                @(negedge clk);
                t++;
            end
        end
        check("byte_count", 32'(n), 32'(n_exp));
        check("copi_cmd", 32'(seen_cmd), 32'h03);
        check("copi_addr", 32'(seen_addr), 32'(a));
        check("cs_gap", 32'(last_high_run >= 2), 32'd1);
        t = 0;
        while (gnt !== 2'b00 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("gnt_release", 32'(gnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'hA5;
        mem[16'h1234] = 8'h11;
        mem[16'h1235] = 8'h22;
        mem[16'h1236] = 8'h33;
        mem[16'h1237] = 8'h44;

        rst_n = 1'b0;
        req   = 2'b00;
        addr0 = '0;
        addr1 = '0;
        len0  = '0;
        len1  = '0;
        last_win = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_copi", 32'(spi_copi), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte from address 0
        addr0 = 16'h0000;
        len0  = 8'd0;
        req   = 2'b01;
        txn(2'b01, 1, -1, 1'b0);

        // Both ports held: grants alternate
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_win = 1'b1;
        addr0 = 16'($urandom);
        addr1 = 16'($urandom);
        len0  = 8'd0;
        len1  = 8'd1;
        req   = 2'b11;
        txn(2'b01, 1, -1, 1'b1);
        txn(2'b10, 2, -1, 1'b1);
        txn(2'b01, 1, -1, 1'b0);

        // Four-byte burst on port 1
        addr1 = 16'h1234;
        len1  = 8'd3;
        req   = 2'b10;
        txn(2'b10, 4, -1, 1'b0);

        // Drop request mid byte 2 of an 8-byte burst
        addr1 = 16'($urandom);
        len1  = 8'd7;
        req   = 2'b10;
        txn(2'b10, 3, 89, 1'b0);

        // Drop during address phase: first byte is the last
        addr0 = 16'($urandom);
        len0  = 8'd5;
        req   = 2'b01;
        txn(2'b01, 1, 30, 1'b0);

        // Reset during ADDR aborts immediately
        addr0 = 16'h5A5A;
        len0  = 8'd4;
        req   = 2'b01;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sck", 32'(spi_sck), 32'd0);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(rd_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_win = 1'b1;
        addr0 = 16'hBEEF;
        len0  = 8'd1;
        req   = 2'b01;
        txn(2'b01, 2, -1, 1'b0);

        // Top-of-memory address, device wraps
        addr0 = 16'hFFFF;
        len0  = 8'd1;
        req   = 2'b01;
        txn(2'b01, 2, -1, 1'b0);

        // Grant and reset on the same edge: reset wins
        repeat (4) @(negedge clk);
        req   = 2'b01;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_vs_grant_gnt", 32'(gnt), 32'd0);
        check("rst_vs_grant_cs", 32'(spi_cs_n), 32'd1);
        req   = 2'b00;
        rst_n = 1'b1;
        last_win = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized requests against the round-robin model
        for (int i = 0; i < 8; i++) begin
            r     = 2'($urandom_range(1, 3));
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            len0  = 8'($urandom_range(0, 3));
            len1  = 8'($urandom_range(0, 3));
            w     = (r == 2'b11) ? ~last_win : r[1];
            req   = r;
            txn(w ? 2'b10 : 2'b01, (w ? int'(len1) : int'(len0)) + 1, -1, 1'b0);
            repeat (3) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
